key_debounce_capture: RTL and testbench

- Conditions the raw DE2-115 pushbuttons (KEY[3:0], active-low, mechanically bouncy) before they reach the Nios pushbutton PIO input.
- Per key, it synchronises, debounces, and produces:
  - a clean active-high level;
  - one-cycle press and release pulses;
  - a sticky edge-capture register with write-1-to-clear, so software never misses a short press.
- Sits directly upstream of the pushbutton PIO export in the top-level wrapper.

---
 rtl/key_debounce_pkg.sv | 14 +
 rtl/key_debounce_ch.sv | 99 +++++++++
 rtl/key_debounce_capture.sv | 50 +++++
 tb/tb_key_debounce_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the pushbutton debounce/capture block.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP,
    WAIT_DOWN,
    DOWN,
    WAIT_UP
  } kstate_t;

  localparam int SYNC_STAGES       = 2;
  localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: synchroniser, debounce FSM with stability counter,
// and registered level / press / release outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;
  kstate_t                state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;

  // Presetting to 1 keeps a released key from looking pressed after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
    end
  end

  assign key_s = ~sync_q[SYNC_STAGES-1];

  // Pulses are derived from the state one cycle after the transition, so they
  // line up with the level_q edge; a DOWN reached from WAIT_UP (aborted
  // release) already has level_q high and therefore yields no press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= (state_q == DOWN) || (state_q == WAIT_UP);
      press_q   <= (state_q == DOWN) && !level_q;
      release_q <= (state_q == UP) && level_q;
      case (state_q)
        UP: begin
          if (key_s) begin
            state_q <= WAIT_DOWN;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT_DOWN: begin
          if (!key_s) begin
            state_q <= UP;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DOWN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DOWN: begin
          if (!key_s) begin
            state_q <= WAIT_UP;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT_UP: begin
          if (key_s) begin
            state_q <= DOWN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= UP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= UP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_capture.sv
// Debounces the active-low board pushbuttons and keeps sticky press flags
// with write-1-to-clear for the pushbutton PIO.
module key_debounce_capture
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS    = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] edge_capture,
  input  logic [N_KEYS-1:0] edge_clear
);

  logic [N_KEYS-1:0] ecap_q;
  logic [N_KEYS-1:0] ecap_d;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_raw_i(key_raw[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g])
    );
  end

  // A press arriving in the same cycle as a clear must not be lost.
  always_comb begin
    ecap_d = (ecap_q & ~edge_clear) | key_press;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ecap_q <= '0;
    end else begin
      ecap_q <= ecap_d;
    end
  end

  assign edge_capture = ecap_q;

endmodule

// File: tb/tb_key_debounce_capture.sv
// Self-checking bench for key_debounce_capture: directed scenarios with fixed
// expectations plus randomized key activity checked against a run-length model.
module tb_key_debounce_capture;

  localparam int NK = 4;
  localparam int DB = 8;

  logic          clk;
  logic          resetN;
  logic [NK-1:0] keyRaw;
  logic [NK-1:0] keyLevel;
  logic [NK-1:0] keyPress;
  logic [NK-1:0] keyRelease;
  logic [NK-1:0] edgeCapture;
  logic [NK-1:0] edgeClear;

  int assertCount = 0;
  int failCount   = 0;

  key_debounce_capture #(
    .N_KEYS   (NK),
    .DB_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset_n     (resetN),
    .key_raw     (keyRaw),
    .key_level   (keyLevel),
    .key_press   (keyPress),
    .key_release (keyRelease),
    .edge_capture(edgeCapture),
    .edge_clear  (edgeClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] raw, input logic [NK-1:0] clr);
    @(negedge clk);
    keyRaw    = raw;
    edgeClear = clr;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // Reference model: a key's accepted level flips once the synchronised
  // (two-sample-delayed, inverted) raw value has disagreed with it for DB
  // samples in a row; outputs show up one cycle after that decision.
  logic [NK-1:0] mRaw1 = '1, mRaw2 = '1;
  logic [NK-1:0] mAcc = '0, mFlipUp = '0, mFlipDn = '0;
  int            mRun [NK];
  logic [NK-1:0] expLevel = '0, expPress = '0, expRelease = '0, expEcap = '0;

  initial begin
    for (int i = 0; i < NK; i++) mRun[i] = 0;
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) begin
        mRaw1 = '1; mRaw2 = '1; mAcc = '0; mFlipUp = '0; mFlipDn = '0;
        expLevel = '0; expPress = '0; expRelease = '0; expEcap = '0;
        for (int i = 0; i < NK; i++) mRun[i] = 0;
      end else begin
        expEcap    = expPress | (expEcap & ~edgeClear);
        expLevel   = mAcc;
        expPress   = mFlipUp;
        expRelease = mFlipDn;
        for (int i = 0; i < NK; i++) begin
          logic sNow;
          sNow       = ~mRaw2[i];
          mFlipUp[i] = 1'b0;
          mFlipDn[i] = 1'b0;
          if (sNow != mAcc[i]) begin
            mRun[i]++;
            if (mRun[i] == DB) begin
              mAcc[i] = sNow;
              mRun[i] = 0;
              if (sNow) mFlipUp[i] = 1'b1;
              else      mFlipDn[i] = 1'b1;
            end
          end else begin
            mRun[i] = 0;
          end
        end
        mRaw2 = mRaw1;
        mRaw1 = keyRaw;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      checkOutput("model_level",   16'(keyLevel),    16'(expLevel));
      checkOutput("model_press",   16'(keyPress),    16'(expPress));
      checkOutput("model_release", 16'(keyRelease),  16'(expRelease));
      checkOutput("model_ecap",    16'(edgeCapture), 16'(expEcap));
    end
  end

  initial begin
    int nPulse;
    int pulseAt;
    int holdLeft [NK];

    resetN    = 1'b0;
    keyRaw    = 4'hF;
    edgeClear = 4'h0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    // Idle after reset: nothing may move.
    for (int i = 0; i < 50; i++) begin
      waitEdges(1);
      checkOutput("idle_all", {keyLevel, keyPress, keyRelease, edgeCapture}, 16'h0);
    end

    // Clean press on key 0, then release at cycle 40.
    applyStimulus(4'hE, 4'h0);
    waitEdges(10);
    checkOutput("k0_level_c10", 16'(keyLevel[0]), 16'h0);
    waitEdges(1);
    checkOutput("k0_level_c11", 16'(keyLevel[0]), 16'h1);
    checkOutput("k0_press_c11", 16'(keyPress), 16'h1);
    waitEdges(1);
    checkOutput("k0_press_c12", 16'(keyPress), 16'h0);
    checkOutput("k0_ecap_c12", 16'(edgeCapture), 16'h1);
    repeat (28) @(negedge clk);
    applyStimulus(4'hF, 4'h0);
    waitEdges(10);
    checkOutput("k0_rel_c50", 16'(keyRelease), 16'h0);
    checkOutput("k0_level_c50", 16'(keyLevel[0]), 16'h1);
    waitEdges(1);
    checkOutput("k0_rel_c51", 16'(keyRelease), 16'h1);
    checkOutput("k0_level_c51", 16'(keyLevel[0]), 16'h0);
    waitEdges(1);
    checkOutput("k0_rel_c52", 16'(keyRelease), 16'h0);
    applyStimulus(4'hF, 4'h1);
    applyStimulus(4'hF, 4'h0);
    waitEdges(1);
    checkOutput("k0_ecap_cleared", 16'(edgeCapture), 16'h0);

    // Key 1 bounces every 3 cycles, then settles pressed.
    for (int t = 0; t < 10; t++) begin
      applyStimulus((t % 2 == 0) ? 4'hD : 4'hF, 4'h0);
      repeat (3) begin
        @(posedge clk);
        #3;
        checkOutput("bounce_no_press", 16'(keyPress), 16'h0);
      end
    end
    applyStimulus(4'hD, 4'h0);
    nPulse  = 0;
    pulseAt = 0;
    for (int j = 1; j <= 20; j++) begin
      waitEdges(1);
      if (keyPress[1]) begin
        nPulse++;
        pulseAt = j;
      end
    end
    checkOutput("bounce_pulse_count", 16'(nPulse), 16'd1);
    checkOutput("bounce_pulse_cycle", 16'(pulseAt), 16'd11);

    // Key 2: capture, then clear colliding with a fresh press, then a lone clear.
    applyStimulus(4'h9, 4'h0);
    waitEdges(11);
    checkOutput("k2_press1", 16'(keyPress), 16'h4);
    applyStimulus(4'hD, 4'h0);
    waitEdges(11);
    checkOutput("k2_release", 16'(keyRelease), 16'h4);
    checkOutput("k2_ecap_before", 16'(edgeCapture), 16'h6);
    applyStimulus(4'h9, 4'h0);
    waitEdges(11);
    checkOutput("k2_press2", 16'(keyPress), 16'h4);
    applyStimulus(4'h9, 4'h4);
    waitEdges(1);
    checkOutput("k2_set_beats_clear", 16'(edgeCapture), 16'h6);
    applyStimulus(4'h9, 4'h0);
    applyStimulus(4'h9, 4'h4);
    applyStimulus(4'h9, 4'h0);
    waitEdges(1);
    checkOutput("k2_lone_clear", 16'(edgeCapture), 16'h2);

    // Keys 0 and 3 pressed together.
    applyStimulus(4'h9, 4'hF);
    applyStimulus(4'h0, 4'h0);
    waitEdges(11);
    checkOutput("k03_press", 16'(keyPress), 16'h9);
    waitEdges(1);
    checkOutput("k03_press_gone", 16'(keyPress), 16'h0);
    checkOutput("k03_ecap", 16'(edgeCapture), 16'h9);

    // Reset while key 1 is mid-count, key kept held through reset.
    applyStimulus(4'hF, 4'h0);
    repeat (15) @(posedge clk);
    applyStimulus(4'hD, 4'h0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checkOutput("reset_immediate", {keyLevel, keyPress, keyRelease, edgeCapture}, 16'h0);
    @(negedge clk);
    resetN = 1'b1;
    waitEdges(10);
    checkOutput("rst_hold_press_c10", 16'(keyPress), 16'h0);
    waitEdges(1);
    checkOutput("rst_hold_press_c11", 16'(keyPress), 16'h2);
    checkOutput("rst_hold_level_c11", 16'(keyLevel), 16'h2);

    // Randomized activity, checked by the model every cycle.
    for (int i = 0; i < NK; i++) holdLeft[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if (holdLeft[k] == 0) begin
          keyRaw[k]   = 1'($urandom_range(0, 1));
          holdLeft[k] = int'($urandom_range(1, 14));
        end
        holdLeft[k]--;
        edgeClear[k] = ($urandom_range(0, 7) == 0);
      end
      resetN = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    resetN    = 1'b1;
    edgeClear = 4'h0;
    repeat (5) @(posedge clk);
    #4;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
